// File: rtl/svc_rv_redir_ctrl_if.sv
// Redirect-controller bus: PC-change requests in, PC-stage select/targets out.
interface svc_rv_redir_ctrl_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned EPOCH_W = 2
);
    logic               stall_pc;
    logic               trap_valid;
    logic [XLEN-1:0]    trap_tgt;
    logic               ex_redir_valid;
    logic [XLEN-1:0]    ex_redir_tgt;
    logic               id_pred_valid;
    logic [XLEN-1:0]    id_pred_tgt;
    logic               btb_pred_valid;
    logic [XLEN-1:0]    btb_tgt;
    logic [1:0]         pc_sel;
    logic [XLEN-1:0]    pc_redir_tgt;
    logic [XLEN-1:0]    pred_tgt;
    logic               btb_pred_taken;
    logic               flush_if;
    logic [EPOCH_W-1:0] epoch;

    modport slave (
        input  stall_pc, trap_valid, trap_tgt, ex_redir_valid, ex_redir_tgt,
               id_pred_valid, id_pred_tgt, btb_pred_valid, btb_tgt,
        output pc_sel, pc_redir_tgt, pred_tgt, btb_pred_taken, flush_if, epoch
    );

    modport master (
        output stall_pc, trap_valid, trap_tgt, ex_redir_valid, ex_redir_tgt,
               id_pred_valid, id_pred_tgt, btb_pred_valid, btb_tgt,
        input  pc_sel, pc_redir_tgt, pred_tgt, btb_pred_taken, flush_if, epoch
    );
endinterface

// File: rtl/svc_rv_redir_ctrl.sv
// Front-end redirect arbiter: merges trap/EX/ID/BTB PC changes, holds them across
// PC stalls, and produces the wrong-path flush window and fetch epoch.
module svc_rv_redir_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned EPOCH_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    svc_rv_redir_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    // Encoding order is the priority order; a larger value wins.
    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_BTB  = 3'd1,
        CLS_ID   = 3'd2,
        CLS_EX   = 3'd3,
        CLS_TRAP = 3'd4
    } cls_e;

    typedef enum logic {IDLE, HOLD} state_e;

    state_e             state_q,    state_d;
    cls_e               pend_cls_q, pend_cls_d;
    logic [XLEN-1:0]    pend_tgt_q, pend_tgt_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [EPOCH_W-1:0] epoch_q,    epoch_d;

    cls_e            live_cls, pend_vis, eff_cls;
    logic [XLEN-1:0] live_tgt, eff_tgt;
    logic            flush;

    assign flush        = (cnt_q != '0);
    assign bus.flush_if = flush;
    assign bus.epoch    = epoch_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_cls_q <= CLS_NONE;
            pend_tgt_q <= '0;
            cnt_q      <= '0;
            epoch_q    <= '0;
        end else begin
            state_q    <= state_d;
            pend_cls_q <= pend_cls_d;
            pend_tgt_q <= pend_tgt_d;
            cnt_q      <= cnt_d;
            epoch_q    <= epoch_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        pend_cls_d         = pend_cls_q;
        pend_tgt_d         = pend_tgt_q;
        cnt_d              = cnt_q;
        epoch_d            = epoch_q;
        live_cls           = CLS_NONE;
        live_tgt           = '0;
        pend_vis           = CLS_NONE;
        eff_cls            = CLS_NONE;
        eff_tgt            = '0;
        bus.pc_sel         = 2'd0;
        bus.pc_redir_tgt   = '0;
        bus.pred_tgt       = '0;
        bus.btb_pred_taken = 1'b0;

        // Predictions are wrong-path while the flush window is open.
        if (bus.trap_valid) begin
            live_cls = CLS_TRAP;
            live_tgt = bus.trap_tgt;
        end else if (bus.ex_redir_valid) begin
            live_cls = CLS_EX;
            live_tgt = bus.ex_redir_tgt;
        end else if (bus.id_pred_valid && !flush) begin
            live_cls = CLS_ID;
            live_tgt = bus.id_pred_tgt;
        end else if (bus.btb_pred_valid && !flush) begin
            live_cls = CLS_BTB;
            live_tgt = bus.btb_tgt;
        end

        if (state_q == HOLD && !(flush && pend_cls_q <= CLS_ID)) begin
            pend_vis = pend_cls_q;
        end

        // Live wins a tie of class against the held request.
        if (pend_vis > live_cls) begin
            eff_cls = pend_vis;
            eff_tgt = pend_tgt_q;
        end else begin
            eff_cls = live_cls;
            eff_tgt = live_tgt;
        end

        case (eff_cls)
            CLS_TRAP, CLS_EX: begin
                bus.pc_sel       = 2'd2;
                bus.pc_redir_tgt = eff_tgt;
            end
            CLS_ID: begin
                bus.pc_sel   = 2'd1;
                bus.pred_tgt = eff_tgt;
            end
            CLS_BTB: begin
                bus.pc_sel         = 2'd1;
                bus.pred_tgt       = eff_tgt;
                bus.btb_pred_taken = 1'b1;
            end
            default: ;
        endcase

        if (bus.stall_pc) begin
            state_d    = (eff_cls == CLS_NONE) ? IDLE : HOLD;
            pend_cls_d = eff_cls;
            pend_tgt_d = eff_tgt;
        end else begin
            state_d    = IDLE;
            pend_cls_d = CLS_NONE;
            pend_tgt_d = '0;
            if (eff_cls == CLS_TRAP || eff_cls == CLS_EX) begin
                cnt_d   = CNT_W'(FLUSH_CYCLES);
                epoch_d = epoch_q + EPOCH_W'(1);
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_svc_rv_redir_ctrl.sv
// Bench for svc_rv_redir_ctrl: directed scenarios plus random traffic, each cycle
// compared against a priority-list reference model.
module tb_svc_rv_redir_ctrl;
    localparam int FLUSH_N = 2;
    localparam int EPOCHS  = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    svc_rv_redir_ctrl_if #(.XLEN(32), .EPOCH_W(2)) bus ();

    svc_rv_redir_ctrl #(.XLEN(32), .FLUSH_CYCLES(FLUSH_N), .EPOCH_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: held request as a rank in the list [trap, ex, id, btb].
    bit          m_pvalid;
    int          m_prank;
    logic [31:0] m_ptgt;
    int          m_cnt;
    int          m_epoch;
    int          e_rank;
    logic [31:0] e_tgt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        logic        lv[4];
        logic [31:0] lt[4];
        bit          fl;
        lv[0] = bus.trap_valid;     lt[0] = bus.trap_tgt;
        lv[1] = bus.ex_redir_valid; lt[1] = bus.ex_redir_tgt;
        lv[2] = bus.id_pred_valid;  lt[2] = bus.id_pred_tgt;
        lv[3] = bus.btb_pred_valid; lt[3] = bus.btb_tgt;
        fl = (m_cnt != 0);
        e_rank = -1;
        e_tgt  = '0;
        for (int r = 0; r < 4; r++) begin
            if (e_rank < 0 && !(fl && r >= 2)) begin
                if (lv[r]) begin
                    e_rank = r; e_tgt = lt[r];
                end else if (m_pvalid && m_prank == r) begin
                    e_rank = r; e_tgt = m_ptgt;
                end
            end
        end
    endtask

    task automatic model_check();
        int sel;
        sel = (e_rank < 0) ? 0 : (e_rank <= 1 ? 2 : 1);
        chk("pc_sel",         32'(bus.pc_sel), 32'(sel));
        chk("pc_redir_tgt",   bus.pc_redir_tgt, (sel == 2) ? e_tgt : 32'h0);
        chk("pred_tgt",       bus.pred_tgt, (sel == 1) ? e_tgt : 32'h0);
        chk("btb_pred_taken", 32'(bus.btb_pred_taken), 32'(e_rank == 3));
        chk("flush_if",       32'(bus.flush_if), 32'(m_cnt != 0));
        chk("epoch",          32'(bus.epoch), 32'(m_epoch));
    endtask

    task automatic model_update();
        if (rst) begin
            m_pvalid = 0; m_prank = 0; m_ptgt = '0; m_cnt = 0; m_epoch = 0;
        end else if (bus.stall_pc) begin
            m_pvalid = (e_rank >= 0);
            m_prank  = e_rank;
            m_ptgt   = e_tgt;
        end else begin
            m_pvalid = 0;
            if (e_rank == 0 || e_rank == 1) begin
                m_cnt   = FLUSH_N;
                m_epoch = (m_epoch + 1) % EPOCHS;
            end else if (m_cnt > 0) begin
                m_cnt--;
            end
        end
    endtask

    task automatic step(input logic st, input logic tv, input logic [31:0] tt,
                        input logic ev, input logic [31:0] et,
                        input logic iv, input logic [31:0] it,
                        input logic bv, input logic [31:0] bt);
        bus.stall_pc       = st;
        bus.trap_valid     = tv; bus.trap_tgt     = tt;
        bus.ex_redir_valid = ev; bus.ex_redir_tgt = et;
        bus.id_pred_valid  = iv; bus.id_pred_tgt  = it;
        bus.btb_pred_valid = bv; bus.btb_tgt      = bt;
        @(negedge clk);
        model_eval();
        if (!rst) model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        m_cnt    = 0;
        m_epoch  = 0;
        m_pvalid = 0;
        m_prank  = 0;
        m_ptgt   = '0;
        do_reset();
        do_reset();
        idle();

        // EX redirect, then flush window of two cycles.
        step(0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
        chk("ex_epoch", 32'(bus.epoch), 32'd1);
        idle(); idle(); idle();

        // Held ID prediction replayed on stall release.
        step(1, 0, 0, 0, 0, 1, 32'h40, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(); idle();

        // Held BTB prediction overwritten by EX redirect mid-stall.
        step(1, 0, 0, 0, 0, 0, 0, 1, 32'h80);
        step(1, 0, 0, 1, 32'h200, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("held_ex_epoch", 32'(bus.epoch), 32'd2);
        idle(); idle();

        // Trap beats EX in the same cycle.
        step(0, 1, 32'h8, 1, 32'h300, 0, 0, 0, 0);
        idle(); idle(); idle();

        // BTB prediction suppressed inside the flush window, honoured after.
        step(0, 0, 0, 1, 32'h500, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h50);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h50);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h50);
        idle();

        // Epoch wrap after four redirects from reset.
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'h1000 + 32'(i), 0, 0, 0, 0);
        chk("epoch_wrap", 32'(bus.epoch), 32'd0);
        idle(); idle();

        // Reset while a request is held drops it.
        step(0, 0, 0, 1, 32'h600, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 32'h44, 0, 0);
        do_reset();
        chk("rst_hold_epoch", 32'(bus.epoch), 32'd0);
        idle();
        chk("rst_hold_sel", 32'(bus.pc_sel), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            step($urandom_range(0, 1) == 1,
                 $urandom_range(0, 11) == 0, $urandom,
                 $urandom_range(0, 7) == 0,  $urandom,
                 $urandom_range(0, 3) == 0,  $urandom,
                 $urandom_range(0, 2) == 0,  $urandom);
        end
        rst = 1'b0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
